// File: rtl/trig_capture.sv
// trig_capture: trigger-and-capture stage between the ADC sample stream and the
// display controller.
//
// Decimates the incoming sample stream, fills a pre-trigger window, waits for a
// level/edge trigger (or a forced trigger on timeout in auto mode), records the
// post-trigger samples, then holds the completed capture until the next display
// frame start. Storage is a ping-pong pair of banks so the displayed trace only
// changes atomically at a frame boundary.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   sample_in    ADC sample (DW bits), qualified by sample_en
//   sample_en    one-cycle strobe per valid ADC sample
//   trig_level   trigger threshold (unsigned)
//   trig_edge    0 = rising, 1 = falling
//   decim        keep 1 of every (decim+1) strobed samples
//   auto_mode    enable forced trigger after AUTO_TO kept samples in ARMED
//   frame_sync   display frame start pulse; swaps banks when a capture is done
//   rd_addr      display column to read
//   rd_data      registered read data, valid 1 clk after rd_addr
//   cap_done     write bank complete, waiting for frame_sync
//   disp_valid   read bank holds a complete capture
//   trig_forced  read-bank capture was auto-triggered
module trig_capture #(
    parameter int unsigned DW        = 10,
    parameter int unsigned DEPTH     = 640,
    parameter int unsigned AW        = 10,
    parameter int unsigned PRE_DEPTH = 320,
    parameter int unsigned AUTO_TO   = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_en,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_edge,
    input  logic [3:0]    decim,
    input  logic          auto_mode,
    input  logic          frame_sync,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          cap_done,
    output logic          disp_valid,
    output logic          trig_forced
);

    // One counter serves the PRE fill, the ARMED timeout and the POST length.
    localparam int unsigned CntMax   = (AUTO_TO > DEPTH) ? AUTO_TO : DEPTH;
    localparam int unsigned CW       = $clog2(CntMax + 1);
    localparam int unsigned PostLen  = DEPTH - PRE_DEPTH - 1;

    localparam logic [CW-1:0] PreLast  = CW'(PRE_DEPTH - 1);
    localparam logic [CW-1:0] AutoLast = CW'(AUTO_TO - 1);
    localparam logic [CW-1:0] PostLast = CW'(PostLen - 1);
    localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   BackOff  = (AW + 1)'(DEPTH - PRE_DEPTH);
    localparam logic [AW-1:0] WpLast   = AW'(DEPTH - 1);

    typedef enum logic [1:0] {StPre, StArmed, StPost, StDone} state_e;

    state_e        state_q, state_d;
    logic          wb_q, wb_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [3:0]    dc_q, dc_d;
    logic [3:0]    decim_l_q, decim_l_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          prev_ok_q, prev_ok_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] tp_q, tp_d;
    logic          forced_q, forced_d;
    logic [AW-1:0] start_q, start_d;
    logic          disp_valid_q, disp_valid_d;
    logic          trig_forced_q, trig_forced_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    logic          keep;
    logic          trig_hit;
    logic [AW-1:0] wp_inc;
    logic [AW:0]   start_sum;
    logic [AW:0]   rd_sum;
    logic [AW-1:0] rd_phys;

    // Samples arriving while a finished capture waits for frame_sync are dropped.
    assign keep = sample_en && (state_q != StDone) && (dc_q == decim_l_q);

    assign trig_hit = prev_ok_q &&
                      (trig_edge ? ((prev_q >= trig_level) && (sample_in < trig_level))
                                 : ((prev_q < trig_level) && (sample_in >= trig_level)));

    assign wp_inc = (wp_q == WpLast) ? '0 : wp_q + 1'b1;

    // Display start = (tp - PRE_DEPTH) mod DEPTH, computed as tp + (DEPTH - PRE_DEPTH).
    always_comb begin
        start_sum = {1'b0, tp_q} + BackOff;
        if (start_sum >= DepthW) begin
            start_sum = start_sum - DepthW;
        end
    end

    always_comb begin
        state_d       = state_q;
        wb_d          = wb_q;
        wp_d          = wp_q;
        dc_d          = dc_q;
        decim_l_d     = decim_l_q;
        prev_d        = prev_q;
        prev_ok_d     = prev_ok_q;
        cnt_d         = cnt_q;
        tp_d          = tp_q;
        forced_d      = forced_q;
        start_d       = start_q;
        disp_valid_d  = disp_valid_q;
        trig_forced_d = trig_forced_q;

        if (sample_en && (state_q != StDone)) begin
            dc_d = keep ? 4'd0 : dc_q + 4'd1;
        end

        if (keep) begin
            wp_d      = wp_inc;
            prev_d    = sample_in;
            prev_ok_d = 1'b1;
        end

        unique case (state_q)
            StPre: begin
                if (keep) begin
                    if (cnt_q == PreLast) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StArmed: begin
                if (keep) begin
                    if (trig_hit || (auto_mode && (cnt_q >= AutoLast))) begin
                        tp_d     = wp_q;
                        forced_d = !trig_hit;
                        cnt_d    = '0;
                        state_d  = (PostLen == 0) ? StDone : StPost;
                    end else if (cnt_q < AutoLast) begin
                        // Saturates so ARMED can persist indefinitely without auto mode.
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StPost: begin
                if (keep) begin
                    if (cnt_q == PostLast) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (frame_sync) begin
                    wb_d          = !wb_q;
                    start_d       = start_sum[AW-1:0];
                    trig_forced_d = forced_q;
                    disp_valid_d  = 1'b1;
                    state_d       = StPre;
                    dc_d          = '0;
                    decim_l_d     = decim;
                    prev_ok_d     = 1'b0;
                    cnt_d         = '0;
                end
            end
            default: state_d = StPre;
        endcase
    end

    // Read path uses next-state bank/start so an address presented in the swap
    // cycle already returns data from the newly displayed bank.
    always_comb begin
        rd_sum = {1'b0, rd_addr} + {1'b0, start_d};
        if (rd_sum >= DepthW) begin
            rd_sum = rd_sum - DepthW;
        end
        rd_phys   = rd_sum[AW-1:0];
        rd_data_d = '0;
        if (disp_valid_d && ({1'b0, rd_addr} < DepthW)) begin
            rd_data_d = wb_d ? mem0[rd_phys] : mem1[rd_phys];
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            if (wb_q) begin
                mem1[wp_q] <= sample_in;
            end else begin
                mem0[wp_q] <= sample_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StPre;
            wb_q          <= 1'b0;
            wp_q          <= '0;
            dc_q          <= '0;
            decim_l_q     <= '0;
            prev_q        <= '0;
            prev_ok_q     <= 1'b0;
            cnt_q         <= '0;
            tp_q          <= '0;
            forced_q      <= 1'b0;
            start_q       <= '0;
            disp_valid_q  <= 1'b0;
            trig_forced_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wb_q          <= wb_d;
            wp_q          <= wp_d;
            dc_q          <= dc_d;
            decim_l_q     <= decim_l_d;
            prev_q        <= prev_d;
            prev_ok_q     <= prev_ok_d;
            cnt_q         <= cnt_d;
            tp_q          <= tp_d;
            forced_q      <= forced_d;
            start_q       <= start_d;
            disp_valid_q  <= disp_valid_d;
            trig_forced_q <= trig_forced_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign cap_done    = (state_q == StDone);
    assign disp_valid  = disp_valid_q;
    assign trig_forced = trig_forced_q;

endmodule

// File: tb/tb_trig_capture.sv
// Directed testbench for trig_capture: rising/falling triggers, decimation,
// auto-trigger timeout, bank-swap rules, read latency and asynchronous reset.
module tb_trig_capture;

    localparam int DW = 10;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sample_in;
    logic          sample_en;
    logic [DW-1:0] trig_level;
    logic          trig_edge;
    logic [3:0]    decim;
    logic          auto_mode;
    logic          frame_sync;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          cap_done;
    logic          disp_valid;
    logic          trig_forced;

    int n_checks = 0;
    int n_fails  = 0;

    trig_capture #(
        .DW        (10),
        .DEPTH     (640),
        .AW        (10),
        .PRE_DEPTH (320),
        .AUTO_TO   (4096)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_en   (sample_en),
        .trig_level  (trig_level),
        .trig_edge   (trig_edge),
        .decim       (decim),
        .auto_mode   (auto_mode),
        .frame_sync  (frame_sync),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cap_done    (cap_done),
        .disp_valid  (disp_valid),
        .trig_forced (trig_forced)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample strobe, optionally with frame_sync in the same cycle.
    task automatic strobe(input int v, input logic fs);
        @(negedge clk);
        sample_in  = v[DW-1:0];
        sample_en  = 1'b1;
        frame_sync = fs;
        @(negedge clk);
        sample_en  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic rd_check(input string tag, input int a, input int exp, output int got);
        @(negedge clk);
        rd_addr = a[AW-1:0];
        @(negedge clk);
        got = int'(rd_data);
        check(tag, rd_data, exp);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int r320;
        int r321;
        int n_done;
        int bad;
        logic seen;

        sample_in  = '0;
        sample_en  = 1'b0;
        trig_level = 10'd512;
        trig_edge  = 1'b0;
        decim      = 4'd0;
        auto_mode  = 1'b0;
        frame_sync = 1'b0;
        rd_addr    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_cap_done", cap_done, 0);
        check("reset_disp_valid", disp_valid, 0);
        check("reset_trig_forced", trig_forced, 0);
        check("reset_rd_data", rd_data, 0);

        // Rising ramp; frame_sync pulses in PRE, ARMED, POST and on the final write.
        for (int k = 0; k < 832; k++) begin
            if (k == 100 || k == 400 || k == 600) begin
                pulse_fs();
                check("no_swap_midcapture", disp_valid, 0);
            end
            if (k == 831) begin
                check("cap_done_before_last", cap_done, 0);
            end
            strobe(k & 1023, k == 831);
        end
        check("rise_cap_done", cap_done, 1);
        check("no_swap_last_write", disp_valid, 0);
        repeat (4) @(negedge clk);
        check("still_no_swap", disp_valid, 0);
        strobe(5, 1'b0);  // dropped in DONE
        check("done_holds", cap_done, 1);

        trig_edge  = 1'b1;
        trig_level = 10'd300;
        @(negedge clk);
        rd_addr    = 10'd320;
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        check("swap_cycle_read", rd_data, 512);
        check("rise_disp_valid", disp_valid, 1);
        check("cap_done_fell", cap_done, 0);
        check("rise_trig_forced", trig_forced, 0);
        rd_check("rise_319", 319, 511, got);
        @(negedge clk);
        rd_addr = 10'd0;
        #1;
        check("rd_lag_hold", rd_data, 511);
        @(negedge clk);
        check("rise_0", rd_data, 192);
        rd_check("rise_639", 639, 831, got);
        rd_check("addr_700", 700, 0, got);

        // Falling ramp from 1023.
        for (int k = 0; k < 1100; k++) begin
            strobe(1023 - k, 1'b0);
            if (cap_done) break;
        end
        check("fall_cap_done", cap_done, 1);
        trig_edge  = 1'b0;
        trig_level = 10'd512;
        decim      = 4'd3;
        pulse_fs();
        rd_check("fall_320", 320, 299, got);
        rd_check("fall_321", 321, 298, got);
        rd_check("fall_319", 319, 300, got);

        // Decimation by 4; decim changed mid-capture must not take effect.
        for (int j = 0; j < 3000; j++) begin
            if (j == 100) decim = 4'd0;
            strobe(j & 1023, 1'b0);
            if (cap_done) break;
        end
        check("decim_cap_done", cap_done, 1);
        auto_mode = 1'b1;
        pulse_fs();
        rd_check("decim_320", 320, 515, r320);
        rd_check("decim_321", 321, 519, r321);
        check("decim_step", r321 - r320, 4);

        // Auto trigger on a flat signal.
        n_done = 0;
        for (int n = 1; n <= 4800; n++) begin
            strobe(100, 1'b0);
            if (cap_done) begin
                n_done = n;
                break;
            end
        end
        check("auto_count", n_done, 4735);
        auto_mode = 1'b0;
        pulse_fs();
        check("auto_trig_forced", trig_forced, 1);
        bad = 0;
        for (int a = 0; a < 640; a++) begin
            @(negedge clk);
            rd_addr = a[AW-1:0];
            @(negedge clk);
            if (rd_data !== 10'd100) bad++;
        end
        check("auto_all_100", bad, 0);

        // No auto mode: ARMED persists.
        seen = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            strobe(100, 1'b0);
            seen = seen | cap_done;
        end
        check("no_auto_no_done", seen, 0);

        // Trigger, go into POST, then reset asynchronously between edges.
        strobe(600, 1'b0);
        for (int n = 0; n < 50; n++) strobe(600, 1'b0);
        check("post_not_done", cap_done, 0);
        check("pre_reset_rd", rd_data, 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd_data", rd_data, 0);
        check("async_rst_disp_valid", disp_valid, 0);
        check("async_rst_trig_forced", trig_forced, 0);
        check("async_rst_cap_done", cap_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        n_done = 0;
        for (int k = 0; k < 900; k++) begin
            strobe(k & 1023, 1'b0);
            if (cap_done) begin
                n_done = k + 1;
                break;
            end
        end
        check("post_rst_count", n_done, 832);
        check("post_rst_no_valid", disp_valid, 0);
        pulse_fs();
        check("post_rst_valid", disp_valid, 1);
        check("post_rst_forced", trig_forced, 0);
        rd_check("post_rst_320", 320, 512, got);
        rd_check("post_rst_0", 0, 192, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
